ifetch_unit: RTL and testbench

Instruction fetch stage for the RV32I pipeline, and the producer side of the decoder's input interface. It owns the PC and issues word requests to instruction memory over a req/gnt + rvalid protocol. Returned words go into a 2-entry buffer, which presents the head as pc/instr plus the pre-sliced opcode, func3, f7 and immSample fields the decoder consumes. It also handles control-flow redirects from execute, including discarding in-flight responses and faulting on misaligned targets.

---
 rtl/ifetch_unit.sv | 195 +++++++++++++++++++
 tb/tb_ifetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// RV32I instruction fetch: owns the PC, issues single-outstanding word requests,
// buffers returned words in a 2-entry queue and applies redirects from execute.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        nReset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic        f7,
    output logic [24:0] immSample,
    output logic        fetch_fault
);

    typedef enum logic [0:0] {MODE_RUN = 1'b0, MODE_HALT = 1'b1} mode_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    mode_e       mode_r;
    mode_e       mode_nxt_s;
    logic        fault_r;
    logic        fault_nxt_s;
    logic        run_s;
    logic [31:0] fetch_pc_r;
    logic [31:0] tag_pc_r;
    logic [31:0] last_pc_r;
    logic        outstanding_r;
    logic        drop_r;
    logic        started_r;
    logic [31:0] head_pc_r;
    logic [31:0] head_instr_r;
    logic [31:0] tail_pc_r;
    logic [31:0] tail_instr_r;
    logic [1:0]  count_r;
    logic        rsp_s;
    logic        pending_s;
    logic        head_valid_s;
    logic        pop_s;
    logic        push_s;
    logic        req_s;
    logic        acc_s;
    logic [2:0]  occ_s;

    // Mode next-state: only a redirect can enter or leave HALT.
    always_comb begin
        mode_nxt_s  = mode_r;
        fault_nxt_s = fault_r;
        run_s       = 1'b0;
        case (mode_r)
            MODE_RUN:  run_s = 1'b1;
            MODE_HALT: run_s = 1'b0;
            default:   run_s = 1'b0;
        endcase
        if (redirect) begin
            if (redirect_pc[1:0] == 2'b00) begin
                mode_nxt_s  = MODE_RUN;
                fault_nxt_s = 1'b0;
            end else begin
                mode_nxt_s  = MODE_HALT;
                fault_nxt_s = 1'b1;
            end
        end else begin
            mode_nxt_s  = mode_r;
            fault_nxt_s = fault_r;
        end
    end

    // Mode and sticky fault state.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            mode_r  <= MODE_RUN;
            fault_r <= 1'b0;
        end else begin
            mode_r  <= mode_nxt_s;
            fault_r <= fault_nxt_s;
        end
    end

    // rvalid without an outstanding request (e.g. left over from before reset) is ignored.
    assign rsp_s        = imem_rvalid & outstanding_r;
    assign pending_s    = outstanding_r & ~rsp_s;
    assign head_valid_s = run_s & (count_r != 2'd0);
    assign pop_s        = head_valid_s & if_ready & ~redirect;
    assign push_s       = rsp_s & ~drop_r & ~redirect & run_s;
    // Slots committed after this cycle: queue after pop/push plus any unanswered request.
    assign occ_s        = {1'b0, count_r} + {2'b00, push_s} - {2'b00, pop_s} + {2'b00, pending_s};
    assign req_s        = started_r & run_s & ~redirect & (~outstanding_r | rsp_s) & (occ_s < 3'd2);
    assign acc_s        = req_s & imem_gnt;

    // Request/response bookkeeping and the fetch PC.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            started_r     <= 1'b0;
            outstanding_r <= 1'b0;
            drop_r        <= 1'b0;
            fetch_pc_r    <= RESET_PC;
            tag_pc_r      <= 32'h0000_0000;
        end else begin
            started_r <= 1'b1;
            if (acc_s) begin
                outstanding_r <= 1'b1;
            end else if (rsp_s) begin
                outstanding_r <= 1'b0;
            end
            if (redirect && pending_s) begin
                drop_r <= 1'b1;
            end else if (rsp_s) begin
                drop_r <= 1'b0;
            end
            if (redirect && (redirect_pc[1:0] == 2'b00)) begin
                fetch_pc_r <= redirect_pc;
            end else if (acc_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (acc_s) begin
                tag_pc_r <= fetch_pc_r;
            end
        end
    end

    // Two-entry response queue; head always holds the oldest word.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            count_r      <= 2'd0;
            head_pc_r    <= 32'h0000_0000;
            head_instr_r <= NOP_INSTR;
            tail_pc_r    <= 32'h0000_0000;
            tail_instr_r <= NOP_INSTR;
        end else if (redirect) begin
            count_r <= 2'd0;
        end else begin
            case ({pop_s, push_s})
                2'b10: begin
                    head_pc_r    <= tail_pc_r;
                    head_instr_r <= tail_instr_r;
                    count_r      <= count_r - 2'd1;
                end
                2'b01: begin
                    if (count_r == 2'd0) begin
                        head_pc_r    <= tag_pc_r;
                        head_instr_r <= imem_rdata;
                    end else begin
                        tail_pc_r    <= tag_pc_r;
                        tail_instr_r <= imem_rdata;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd2) begin
                        head_pc_r    <= tail_pc_r;
                        head_instr_r <= tail_instr_r;
                        tail_pc_r    <= tag_pc_r;
                        tail_instr_r <= imem_rdata;
                    end else begin
                        head_pc_r    <= tag_pc_r;
                        head_instr_r <= imem_rdata;
                    end
                end
                default: count_r <= count_r;
            endcase
        end
    end

    // Last presented PC, shown on if_pc while the queue is empty.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            last_pc_r <= 32'h0000_0000;
        end else if (head_valid_s) begin
            last_pc_r <= head_pc_r;
        end
    end

    assign imem_req    = req_s;
    assign imem_addr   = fetch_pc_r;
    assign if_valid    = head_valid_s;
    assign if_pc       = head_valid_s ? head_pc_r : last_pc_r;
    assign if_instr    = head_valid_s ? head_instr_r : NOP_INSTR;
    assign opcode      = if_instr[6:0];
    assign func3       = if_instr[14:12];
    assign f7          = if_instr[30];
    assign immSample   = if_instr[31:7];
    assign fetch_fault = fault_r;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a memory responder, a decode-side monitor and
// a stimulus process that runs directed scenarios followed by randomized traffic.
module tb_ifetch_unit;

    logic        clock = 1'b0;
    logic        nReset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        f7;
    logic [24:0] immSample;
    logic        fetch_fault;

    always #5 clock = ~clock;

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .nReset(nReset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .opcode(opcode), .func3(func3), .f7(f7), .immSample(immSample),
        .fetch_fault(fetch_fault)
    );

    int          pass_cnt = 0;
    int          chk_total = 0;
    logic [31:0] exp_q[$];
    bit          halted = 1'b0;
    bit          gnt_rand = 1'b0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          acc_cnt = 0;
    logic [31:0] last_acc = 32'hDEAD_BEEF;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0050_0093;
            32'h0000_0004: mem_word = 32'h00A0_0113;
            32'h0000_0008: mem_word = 32'h0020_81B3;
            default:       mem_word = (a * 32'h9E37_79B1) ^ 32'h1234_5678;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        chk_total++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Expected decode stream from an aligned start: consecutive words, wrapping mod 2^32.
    task automatic load_stream(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(start + 32'(i * 4));
    endtask

    // Memory responder: one outstanding request, programmable latency, random grant.
    initial begin
        bit          pend;
        logic [31:0] pend_addr;
        int          pend_cnt;
        bit          prev_wait;
        logic [31:0] prev_addr;
        pend = 1'b0; pend_addr = 32'h0; pend_cnt = 0; prev_wait = 1'b0; prev_addr = 32'h0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        forever begin
            @(negedge clock);
            if (!nReset) begin
                pend = 1'b0;
                prev_wait = 1'b0;
            end else begin
                if (imem_rvalid) pend = 1'b0;
                if (prev_wait && imem_req) check("addr_stable", imem_addr, prev_addr);
                if (imem_req && imem_gnt) begin
                    check("one_outstanding", {31'b0, pend}, 32'd0);
                    pend = 1'b1;
                    pend_addr = imem_addr;
                    pend_cnt = lat_min + int'($urandom_range(0, lat_max - lat_min));
                    acc_cnt++;
                    last_acc = imem_addr;
                end
                prev_wait = imem_req && !imem_gnt;
                prev_addr = imem_addr;
            end
            @(posedge clock);
            #1;
            if (nReset && pend) begin
                pend_cnt--;
                imem_rvalid = (pend_cnt == 0);
            end else begin
                imem_rvalid = 1'b0;
            end
            imem_rdata = imem_rvalid ? mem_word(pend_addr) : $urandom;
            imem_gnt = gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Decode-side monitor: every accepted head is popped from the scoreboard and compared.
    initial begin
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        forever begin
            @(negedge clock);
            if (nReset) begin
                if (halted && !redirect) check("halt_no_valid", {31'b0, if_valid}, 32'd0);
                if (if_valid && if_ready && !redirect) begin
                    if (exp_q.size() == 0) begin
                        chk_total++;
                        $display("FAIL sb_empty: got pc %h, expected no instruction", if_pc);
                    end else begin
                        e_pc = exp_q.pop_front();
                        e_ins = mem_word(e_pc);
                        check("sb_pc", if_pc, e_pc);
                        check("sb_instr", if_instr, e_ins);
                        check("sb_opcode", {25'b0, opcode}, {25'b0, e_ins[6:0]});
                        check("sb_f3_f7", {28'b0, func3, f7}, {28'b0, e_ins[14:12], e_ins[30]});
                        check("sb_imm", {7'b0, immSample}, {7'b0, e_ins[31:7]});
                    end
                end
            end
        end
    end

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        @(negedge clock);
        while (!if_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!if_valid) timeout_fail(name);
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        @(posedge clock);
        #1;
        redirect = 1'b1;
        redirect_pc = tgt;
        if (tgt[1:0] == 2'b00) begin
            halted = 1'b0;
            load_stream(tgt);
        end else begin
            halted = 1'b1;
            exp_q.delete();
        end
        @(posedge clock);
        #1;
        redirect = 1'b0;
        redirect_pc = $urandom;
        @(negedge clock);
        check("redir_squash", {31'b0, if_valid}, 32'd0);
        check("redir_fault", {31'b0, fetch_fault}, {31'b0, (tgt[1:0] != 2'b00)});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        check({tag, "_valid"}, {31'b0, if_valid}, 32'd0);
        check({tag, "_pc"}, if_pc, 32'h0000_0000);
        check({tag, "_instr"}, if_instr, 32'h0000_0013);
        check({tag, "_opcode"}, {25'b0, opcode}, 32'h0000_0013);
        check({tag, "_fault"}, {31'b0, fetch_fault}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          base;
        logic [31:0] tgt;
        nReset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;
        load_stream(32'h0);
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        @(posedge clock);
        #1 nReset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0000_0000);

        // Back-to-back stream 0,4,8 with the first word's fields.
        wait_valid("a_first_valid");
        check("a_pc0", if_pc, 32'h0000_0000);
        check("a_instr0", if_instr, 32'h0050_0093);
        check("a_opcode0", {25'b0, opcode}, 32'h0000_0013);
        check("a_func3_0", {29'b0, func3}, 32'd0);
        check("a_imm0", {7'b0, immSample}, 32'h0000_A001); // 0x00500093 >> 7
        @(negedge clock);
        check("a_valid1", {31'b0, if_valid}, 32'd1);
        check("a_pc1", if_pc, 32'h0000_0004);
        @(negedge clock);
        check("a_valid2", {31'b0, if_valid}, 32'd1);
        check("a_pc2", if_pc, 32'h0000_0008);
        repeat (15) @(posedge clock);

        // Backpressure: queue fills, requests stop, nothing lost.
        @(posedge clock);
        #1 if_ready = 1'b0;
        repeat (4) @(posedge clock);
        n = acc_cnt;
        repeat (6) @(posedge clock);
        check("bp_no_accept", acc_cnt, n);
        @(negedge clock);
        check("bp_req_low", {31'b0, imem_req}, 32'd0);
        check("bp_valid", {31'b0, if_valid}, 32'd1);
        @(posedge clock);
        #1 if_ready = 1'b1;
        repeat (10) @(posedge clock);

        // Redirect while the 0xC request is outstanding (3-cycle latency).
        lat_min = 3; lat_max = 3;
        do_redirect(32'h0000_0000);
        n = 0;
        @(posedge clock);
        while (last_acc != 32'h0000_000C && n < 60) begin
            @(posedge clock);
            n++;
        end
        if (last_acc != 32'h0000_000C) timeout_fail("c_wait_0xC");
        do_redirect(32'h0000_0100);
        wait_valid("c_valid");
        check("c_redir_pc", if_pc, 32'h0000_0100);
        repeat (10) @(posedge clock);

        // Misaligned redirect halts with a sticky fault until an aligned redirect.
        do_redirect(32'h0000_0102);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("d_halt_req", {31'b0, imem_req}, 32'd0);
            check("d_halt_fault", {31'b0, fetch_fault}, 32'd1);
        end
        do_redirect(32'h0000_0200);
        wait_valid("d_valid");
        check("d_redir_pc", if_pc, 32'h0000_0200);

        // Fetch address wraps past 0xFFFF_FFFC.
        lat_min = 1; lat_max = 1;
        do_redirect(32'hFFFF_FFF0);
        n = 0;
        @(posedge clock);
        while (last_acc != 32'hFFFF_FFFC && n < 40) begin
            @(posedge clock);
            n++;
        end
        if (last_acc != 32'hFFFF_FFFC) timeout_fail("e_wait_top");
        base = acc_cnt;
        n = 0;
        while (acc_cnt == base && n < 40) begin
            @(posedge clock);
            n++;
        end
        if (acc_cnt == base) timeout_fail("e_wait_next");
        else check("e_wrap_addr", last_acc, 32'h0000_0000);
        repeat (10) @(posedge clock);

        // Randomized traffic: grant, latency, ready and redirects.
        gnt_rand = 1'b1; lat_min = 1; lat_max = 3;
        for (int c = 0; c < 400; c++) begin
            @(posedge clock);
            #1 if_ready = ($urandom_range(0, 3) != 0);
            if (($urandom_range(0, 29) == 0) || (!halted && exp_q.size() < 16) ||
                (halted && $urandom_range(0, 5) == 0)) begin
                tgt = $urandom & 32'h0000_3FFC;
                if ($urandom_range(0, 4) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
                do_redirect(tgt);
            end
        end

        // Asynchronous reset mid-stream with the queue full.
        gnt_rand = 1'b0; lat_min = 1; lat_max = 1;
        @(posedge clock);
        #1 if_ready = 1'b1;
        do_redirect(32'h0000_0300);
        repeat (3) @(posedge clock);
        #1 if_ready = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("g_full_valid", {31'b0, if_valid}, 32'd1);
        check("g_full_req", {31'b0, imem_req}, 32'd0);
        @(posedge clock);
        #3 nReset = 1'b0;
        #1;
        check_reset_outputs("g_reset");
        halted = 1'b0;
        load_stream(32'h0);
        @(posedge clock);
        #1 if_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 nReset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("g_restart_req", {31'b0, imem_req}, 32'd1);
        check("g_restart_addr", imem_addr, 32'h0000_0000);
        wait_valid("g_valid");
        check("g_restart_pc", if_pc, 32'h0000_0000);
        repeat (20) @(posedge clock);

        $display("%0d/%0d checks passed", pass_cnt, chk_total);
        $finish;
    end

endmodule
